// File: rtl/route_dist_pipe_pkg.sv
// Shared helpers for the route distributor: constant-width popcount and clog2.
package route_dist_pipe_pkg;

  // Widest map the popcount helper accepts; callers zero-extend into it.
  localparam int POP_MAX = 1024;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int popcnt(input logic [POP_MAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/route_dist_pipe_if.sv
// Payload, lane-bus and config signals of the route distributor.
interface route_dist_pipe_if #(
  parameter int DIN_W  = 70,
  parameter int DOUT_W = 128
) ();
  localparam int IW = route_dist_pipe_pkg::clog2(DOUT_W + 1);

  logic              cfg_we;
  logic [DOUT_W-1:0] cfg_sw;
  logic [IW-1:0]     cfg_lane_cnt;
  logic              cfg_short;
  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] out_data;
  logic              out_short;

  modport slave (
    input  cfg_we, cfg_sw, in_valid, in_data, out_ready,
    output cfg_lane_cnt, cfg_short, in_ready, out_valid, out_data, out_short
  );

  modport master (
    output cfg_we, cfg_sw, in_valid, in_data, out_ready,
    input  cfg_lane_cnt, cfg_short, in_ready, out_valid, out_data, out_short
  );
endinterface

// File: rtl/route_dist_pipe_stage.sv
// One pipeline slice: resolves lanes [STAGE*SEG, (STAGE+1)*SEG) and registers the carry.
module route_dist_pipe_stage #(
  parameter int DIN_W  = 70,
  parameter int DOUT_W = 128,
  parameter int STAGES = 4,
  parameter int STAGE  = 0,
  parameter int IW     = route_dist_pipe_pkg::clog2(DOUT_W + 1),
  parameter int CW     = DIN_W + 2*DOUT_W + IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_vld,
  input  logic [CW-1:0] up_carry,
  output logic          up_rdy,
  output logic          dn_vld,
  output logic [CW-1:0] dn_carry,
  input  logic          dn_rdy
);
  localparam int SEG  = DOUT_W / STAGES;
  localparam int BASE = STAGE * SEG;

  typedef struct packed {
    logic [DIN_W-1:0]  data;
    logic [DOUT_W-1:0] map;
    logic [IW-1:0]     idx;
    logic [DOUT_W-1:0] lanes;
    logic              short;
  } carry_t;

  carry_t        cur, nxt, held;
  logic          vld_q;
  logic [IW-1:0] k;

  assign cur = up_carry;

  // idx counts enabled lanes seen so far; it selects the payload bit for the next enabled lane.
  always_comb begin
    nxt = cur;
    k   = cur.idx;
    for (int j = 0; j < SEG; j++) begin
      if (cur.map[BASE+j]) begin
        nxt.lanes[BASE+j] = |(cur.data & (DIN_W'(1) << k));
        if (k != IW'(DOUT_W)) k = k + IW'(1);
      end
    end
    nxt.idx   = k;
    nxt.short = (int'(k) < DIN_W);
  end

  assign up_rdy = !vld_q | dn_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      held  <= '0;
    end else if (up_rdy) begin
      vld_q <= up_vld;
      if (up_vld) held <= nxt;
    end
  end

  assign dn_vld   = vld_q;
  assign dn_carry = held;
endmodule

// File: rtl/route_dist_pipe.sv
// Pipelined scatter of payload bits onto enabled lanes; holds the lane-enable map.
module route_dist_pipe
  import route_dist_pipe_pkg::*;
#(
  parameter int                DIN_W   = 70,
  parameter int                DOUT_W  = 128,
  parameter int                STAGES  = 4,
  parameter logic [DOUT_W-1:0] CFG_RST = {DOUT_W{1'b1}}
) (
  input logic             clk,
  input logic             rst,
  route_dist_pipe_if.slave bus
);
  localparam int IW = clog2(DOUT_W + 1);
  localparam int CW = DIN_W + 2*DOUT_W + IW + 1;

  typedef struct packed {
    logic [DIN_W-1:0]  data;
    logic [DOUT_W-1:0] map;
    logic [IW-1:0]     idx;
    logic [DOUT_W-1:0] lanes;
    logic              short;
  } carry_t;

  logic [DOUT_W-1:0] map_q;
  logic [IW-1:0]     cnt_q;
  logic              short_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q   <= CFG_RST;
      cnt_q   <= IW'(popcnt(POP_MAX'(CFG_RST)));
      short_q <= popcnt(POP_MAX'(CFG_RST)) < DIN_W;
    end else if (bus.cfg_we) begin
      map_q   <= bus.cfg_sw;
      cnt_q   <= IW'(popcnt(POP_MAX'(bus.cfg_sw)));
      short_q <= popcnt(POP_MAX'(bus.cfg_sw)) < DIN_W;
    end
  end

  assign bus.cfg_lane_cnt = cnt_q;
  assign bus.cfg_short    = short_q;

  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0]         rdy_pipe;
  logic [STAGES:0][CW-1:0] c_pipe;
  carry_t                  c0, c_out;

  // Stage 0 latches map_q at the accept edge, so a same-edge cfg write applies to the next beat.
  always_comb begin
    c0      = '0;
    c0.data = bus.in_data;
    c0.map  = map_q;
  end

  assign c_pipe[0]        = c0;
  assign vld_pipe[0]      = bus.in_valid;
  assign rdy_pipe[STAGES] = bus.out_ready;
  assign bus.in_ready     = rdy_pipe[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    route_dist_pipe_stage #(
      .DIN_W (DIN_W),
      .DOUT_W(DOUT_W),
      .STAGES(STAGES),
      .STAGE (s),
      .IW    (IW),
      .CW    (CW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .up_vld  (vld_pipe[s]),
      .up_carry(c_pipe[s]),
      .up_rdy  (rdy_pipe[s]),
      .dn_vld  (vld_pipe[s+1]),
      .dn_carry(c_pipe[s+1]),
      .dn_rdy  (rdy_pipe[s+1])
    );
  end

  assign c_out         = c_pipe[STAGES];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = c_out.lanes;
  assign bus.out_short = c_out.short;

  logic carry_unused;
  assign carry_unused = ^{c_out.data, c_out.map, c_out.idx};
endmodule

// File: tb/tb_route_dist_pipe.sv
// Scoreboard bench: small (4/8/2) instance for directed/random tests, large (70/128/4) smoke instance.
module tb_route_dist_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  route_dist_pipe_if #(.DIN_W(4),  .DOUT_W(8))   bus_s ();
  route_dist_pipe_if #(.DIN_W(70), .DOUT_W(128)) bus_b ();

  route_dist_pipe #(.DIN_W(4), .DOUT_W(8), .STAGES(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave));
  route_dist_pipe #(.DIN_W(70), .DOUT_W(128), .STAGES(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    logic [127:0] lanes;
    logic         sh;
  } exp_t;

  exp_t q_s[$];
  exp_t q_b[$];
  exp_t em_s, em_b;
  logic [7:0]   map_s;
  logic [127:0] map_b;
  int n_chk = 0;
  int n_fail = 0;
  int n_acc_s = 0;

  // Reference scatter: walk lanes low to high, enabled lanes take successive payload bits.
  function automatic void model(input logic [127:0] m, input logic [69:0] d, input int din,
                                input int dout, output logic [127:0] lanes, output logic sh);
    int k;
    k = 0;
    lanes = '0;
    for (int j = 0; j < dout; j++) begin
      if (m[j]) begin
        if (k < din) lanes[j] = d[k];
        k++;
      end
    end
    sh = (k < din);
  endfunction

  // One clock: bookkeeping at the negedge before the edge, then return at posedge+1.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q_s.delete();
      q_b.delete();
      map_s = '1;
      map_b = '1;
    end else begin
      n_chk++;
      if (bus_s.cfg_lane_cnt !== 4'($countones(map_s)) || bus_s.cfg_short !== ($countones(map_s) < 4)) begin
        n_fail++;
        $display("FAIL cfg_cnt_s: got cnt=%0d short=%b, need cnt=%0d short=%b", bus_s.cfg_lane_cnt,
                 bus_s.cfg_short, $countones(map_s), $countones(map_s) < 4);
      end
      n_chk++;
      if (bus_b.cfg_lane_cnt !== 8'($countones(map_b)) || bus_b.cfg_short !== ($countones(map_b) < 70)) begin
        n_fail++;
        $display("FAIL cfg_cnt_b: got cnt=%0d short=%b, need cnt=%0d short=%b", bus_b.cfg_lane_cnt,
                 bus_b.cfg_short, $countones(map_b), $countones(map_b) < 70);
      end
      if (bus_s.in_valid && bus_s.in_ready) begin
        model(128'(map_s), 70'(bus_s.in_data), 4, 8, e.lanes, e.sh);
        q_s.push_back(e);
        n_acc_s++;
      end
      if (bus_b.in_valid && bus_b.in_ready) begin
        model(map_b, bus_b.in_data, 70, 128, e.lanes, e.sh);
        q_b.push_back(e);
      end
      if (bus_s.cfg_we) map_s = bus_s.cfg_sw;
      if (bus_b.cfg_we) map_b = bus_b.cfg_sw;
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops on every transfer, and checks that stalled beats hold still.
  logic         hold_s = 1'b0, hold_b = 1'b0, hs_s, hs_b;
  logic [7:0]   hd_s;
  logic [127:0] hd_b;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_s) begin
        n_chk++;
        if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== hd_s || bus_s.out_short !== hs_s) begin
          n_fail++;
          $display("FAIL hold_s: got v=%b d=%h s=%b, need v=1 d=%h s=%b", bus_s.out_valid,
                   bus_s.out_data, bus_s.out_short, hd_s, hs_s);
        end
      end
      if (bus_s.out_valid && bus_s.out_ready) begin
        n_chk++;
        if (q_s.size() == 0) begin
          n_fail++;
          $display("FAIL beat_s: got unexpected d=%h, need no beat", bus_s.out_data);
        end else begin
          em_s = q_s.pop_front();
          if (128'(bus_s.out_data) !== em_s.lanes || bus_s.out_short !== em_s.sh) begin
            n_fail++;
            $display("FAIL beat_s: got d=%h s=%b, need d=%h s=%b", bus_s.out_data, bus_s.out_short,
                     em_s.lanes[7:0], em_s.sh);
          end
        end
      end
      if (hold_b) begin
        n_chk++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== hd_b || bus_b.out_short !== hs_b) begin
          n_fail++;
          $display("FAIL hold_b: got v=%b d=%h, need v=1 d=%h", bus_b.out_valid, bus_b.out_data, hd_b);
        end
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        n_chk++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL beat_b: got unexpected d=%h, need no beat", bus_b.out_data);
        end else begin
          em_b = q_b.pop_front();
          if (bus_b.out_data !== em_b.lanes || bus_b.out_short !== em_b.sh) begin
            n_fail++;
            $display("FAIL beat_b: got d=%h s=%b, need d=%h s=%b", bus_b.out_data, bus_b.out_short,
                     em_b.lanes, em_b.sh);
          end
        end
      end
    end
    hold_s = !rst && bus_s.out_valid && !bus_s.out_ready;
    hd_s   = bus_s.out_data;
    hs_s   = bus_s.out_short;
    hold_b = !rst && bus_b.out_valid && !bus_b.out_ready;
    hd_b   = bus_b.out_data;
    hs_b   = bus_b.out_short;
  end

  task automatic send_s(input logic [3:0] d);
    bit done;
    done = 1'b0;
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      done = bus_s.in_ready;
      step();
    end
    bus_s.in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_s: got no accept in 50 cycles, need accept");
    end
  endtask

  task automatic cfg_s(input logic [7:0] m);
    bus_s.cfg_we = 1'b1;
    bus_s.cfg_sw = m;
    step();
    bus_s.cfg_we = 1'b0;
  endtask

  task automatic drain();
    bus_s.in_valid  = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_s.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 100 && (q_s.size() != 0 || q_b.size() != 0); i++) step();
    n_chk++;
    if (q_s.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d beats outstanding, need 0/0", q_s.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_s.cfg_we = 1'b1;   // must be ignored while in reset
    bus_s.cfg_sw = 8'h00;
    step();
    step();
    bus_s.cfg_we = 1'b0;
    rst = 1'b0;
    n_chk++;
    if (bus_s.out_valid !== 1'b0 || bus_s.out_data !== 8'h00 || bus_s.out_short !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b d=%h s=%b, need 0 00 0", bus_s.out_valid, bus_s.out_data,
               bus_s.out_short);
    end
    n_chk++;
    if (bus_s.cfg_lane_cnt !== 4'd8 || bus_s.cfg_short !== 1'b0 || bus_s.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cfg: got cnt=%0d short=%b rdy=%b, need 8 0 1", bus_s.cfg_lane_cnt,
               bus_s.cfg_short, bus_s.in_ready);
    end
  endtask

  task automatic test_latency();
    bus_s.out_ready = 1'b1;
    send_s(4'hA);
    n_chk++;
    if (bus_s.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got out_valid=%b one cycle after accept, need 0", bus_s.out_valid);
    end
    step();
    n_chk++;
    if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== 8'h0A || bus_s.out_short !== 1'b0) begin
      n_fail++;
      $display("FAIL latency: got v=%b d=%h s=%b, need 1 0a 0", bus_s.out_valid, bus_s.out_data,
               bus_s.out_short);
    end
    drain();
  endtask

  task automatic test_maps();
    cfg_s(8'b1010_0101);
    send_s(4'b1011);
    cfg_s(8'b0000_0110);
    n_chk++;
    if (bus_s.cfg_lane_cnt !== 4'd2 || bus_s.cfg_short !== 1'b1) begin
      n_fail++;
      $display("FAIL short_cfg: got cnt=%0d short=%b, need 2 1", bus_s.cfg_lane_cnt, bus_s.cfg_short);
    end
    send_s(4'hF);
    cfg_s(8'h00);
    send_s(4'hF);
    cfg_s(8'hFF);
    send_s(4'h9);
    drain();
  endtask

  task automatic test_cfg_same_edge();
    cfg_s(8'h0F);
    bus_s.cfg_we   = 1'b1;
    bus_s.cfg_sw   = 8'hF0;
    send_s(4'h5);
    bus_s.cfg_we   = 1'b0;
    send_s(4'h5);
    drain();
  endtask

  task automatic test_random();
    int start;
    start = n_acc_s;
    for (int c = 0; c < 20000 && n_acc_s < start + 1000; c++) begin
      bus_s.in_valid  = ($urandom_range(3) != 0);
      bus_s.in_data   = 4'($urandom);
      bus_s.cfg_we    = ($urandom_range(7) == 0);
      bus_s.cfg_sw    = 8'($urandom);
      bus_s.out_ready = ($urandom_range(9) >= 3);
      step();
    end
    bus_s.cfg_we = 1'b0;
    n_chk++;
    if (n_acc_s < start + 1000) begin
      n_fail++;
      $display("FAIL random_accept: got %0d beats, need 1000", n_acc_s - start);
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    bus_s.out_ready = 1'b0;
    send_s(4'h3);
    send_s(4'hC);
    step();
    rst = 1'b1;
    step();
    n_chk++;
    if (bus_s.out_valid !== 1'b0 || bus_s.out_data !== 8'h00 || bus_s.out_short !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flight: got v=%b d=%h s=%b, need 0 00 0", bus_s.out_valid,
               bus_s.out_data, bus_s.out_short);
    end
    rst = 1'b0;
    bus_s.out_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_big();
    for (int c = 0; c < 300; c++) begin
      bus_b.in_valid  = ($urandom_range(3) != 0);
      bus_b.in_data   = 70'({$urandom, $urandom, $urandom});
      bus_b.cfg_we    = ($urandom_range(15) == 0);
      bus_b.cfg_sw    = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(3) == 0) bus_b.cfg_sw = bus_b.cfg_sw & {$urandom, $urandom, $urandom, $urandom};
      bus_b.out_ready = ($urandom_range(9) >= 3);
      step();
    end
    bus_b.cfg_we = 1'b0;
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2ms, need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_s.cfg_we = 1'b0; bus_s.cfg_sw = '0; bus_s.in_valid = 1'b0; bus_s.in_data = '0;
    bus_s.out_ready = 1'b0;
    bus_b.cfg_we = 1'b0; bus_b.cfg_sw = '0; bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    bus_b.out_ready = 1'b0;
    map_s = '1;
    map_b = '1;
    test_reset();
    test_latency();
    test_maps();
    test_cfg_same_edge();
    test_random();
    test_reset_inflight();
    test_big();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
